// File: rtl/instr_queue_reg.sv
// Instruction queue: a small FIFO feeding an instruction register.
// The head is split into opcode and operand fields. ir_q holds the last word popped.
module instr_queue_reg #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int OPCODE_W = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_instr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_instr,
    output logic [OPCODE_W-1:0]          out_opcode,
    output logic [WIDTH-OPCODE_W-1:0]    out_operand,
    output logic [WIDTH-1:0]             ir_q,
    output logic                         ir_valid,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_ir;
    logic             r_ir_valid;
    logic             r_overflow;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_head;

    // Full/empty derive only from registered occupancy, so in_ready never sees out_ready.
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = in_valid && !w_full && !flush;
    assign w_pop   = out_ready && !w_empty && !flush;
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (in_valid && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Instruction register survives flush; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
        end else if (w_pop) begin
            r_ir       <= w_head;
            r_ir_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_instr;
        end
    end

    assign in_ready    = !w_full;
    assign out_valid   = !w_empty;
    // Storage has no reset, so the head is masked whenever the queue is empty.
    assign out_instr   = w_empty ? '0 : w_head;
    assign out_opcode  = out_instr[WIDTH-1 -: OPCODE_W];
    assign out_operand = out_instr[WIDTH-OPCODE_W-1:0];
    assign ir_q        = r_ir;
    assign ir_valid    = r_ir_valid;
    assign count       = r_count;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_instr_queue_reg.sv
// Directed bench for instr_queue_reg with default parameters.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_instr_queue_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_instr = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_instr;
    logic [3:0] out_opcode;
    logic [3:0] out_operand;
    logic [7:0] ir_q;
    logic       ir_valid;
    logic [2:0] count;
    logic       overflow;

    int checks = 0;
    int failures = 0;

    instr_queue_reg #(.WIDTH(8), .DEPTH(4), .OPCODE_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_opcode(out_opcode), .out_operand(out_operand),
        .ir_q(ir_q), .ir_valid(ir_valid), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [7:0] v);
        in_valid = 1'b1;
        in_instr = v;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if ({in_ready, out_valid, out_instr, ir_q, ir_valid, count, overflow} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0}) begin
            failures++; $display("FAIL reset_outputs: rdy=%b ov=%b oi=%h ir=%h irv=%b cnt=%0d of=%b", in_ready, out_valid, out_instr, ir_q, ir_valid, count, overflow);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic_push();
        push_one(8'hA5);
        checks++; if ({out_valid, out_opcode, out_operand, count} !== {1'b1, 4'hA, 4'h5, 3'd1}) begin
            failures++; $display("FAIL basic_push: ov=%b op=%h opd=%h cnt=%0d, want 1 a 5 1", out_valid, out_opcode, out_operand, count);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if ({ir_q, ir_valid, count, out_valid, out_instr} !== {8'hA5, 1'b1, 3'd0, 1'b0, 8'h00}) begin
            failures++; $display("FAIL basic_pop: ir=%h irv=%b cnt=%0d ov=%b oi=%h, want a5 1 0 0 00", ir_q, ir_valid, count, out_valid, out_instr);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if ({ir_q, count} !== {8'hA5, 3'd0}) begin
            failures++; $display("FAIL empty_pop: ir=%h cnt=%0d, want a5 0", ir_q, count);
        end
    endtask

    task automatic test_fill_overflow();
        logic [7:0] vals [4];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) push_one(vals[i]);
        checks++; if ({count, in_ready, overflow} !== {3'd4, 1'b0, 1'b0}) begin
            failures++; $display("FAIL fill: cnt=%0d rdy=%b of=%b, want 4 0 0", count, in_ready, overflow);
        end
        push_one(8'h55);
        checks++; if ({count, overflow, out_instr} !== {3'd4, 1'b1, 8'h11}) begin
            failures++; $display("FAIL overflow_push: cnt=%0d of=%b head=%h, want 4 1 11", count, overflow, out_instr);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_instr !== vals[i]) begin
                failures++; $display("FAIL fill_order[%0d]: got %h want %h", i, out_instr, vals[i]);
            end
            step();
        end
        out_ready = 1'b0;
        checks++; if ({ir_q, ir_valid, count, out_valid, overflow} !== {8'h44, 1'b1, 3'd0, 1'b0, 1'b1}) begin
            failures++; $display("FAIL drain: ir=%h irv=%b cnt=%0d ov=%b of=%b, want 44 1 0 0 1", ir_q, ir_valid, count, out_valid, overflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_pop [6];
        exp_pop = '{8'hE0, 8'hE1, 8'h01, 8'h02, 8'h03, 8'h04};
        push_one(8'hE0);
        push_one(8'hE1);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_instr = 8'(i + 1);
            checks++; if ({out_instr, count} !== {exp_pop[i], 3'd2}) begin
                failures++; $display("FAIL b2b[%0d]: head=%h cnt=%0d want %h 2", i, out_instr, count, exp_pop[i]);
            end
            step();
        end
        in_valid = 1'b0;
        checks++; if ({count, out_instr, ir_q} !== {3'd2, 8'h05, 8'h04}) begin
            failures++; $display("FAIL b2b_end: cnt=%0d head=%h ir=%h, want 2 05 04", count, out_instr, ir_q);
        end
        step();
        checks++; if (out_instr !== 8'h06) begin
            failures++; $display("FAIL b2b_drain: head=%h want 06", out_instr);
        end
        step();
        out_ready = 1'b0;
        checks++; if ({count, ir_q} !== {3'd0, 8'h06}) begin
            failures++; $display("FAIL b2b_empty: cnt=%0d ir=%h, want 0 06", count, ir_q);
        end
    endtask

    task automatic test_full_push_pop();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if ({overflow, count, ir_q} !== {1'b0, 3'd0, 8'h06}) begin
            failures++; $display("FAIL flush_clear: of=%b cnt=%0d ir=%h, want 0 0 06", overflow, count, ir_q);
        end
        for (int i = 0; i < 4; i++) push_one(8'hA1 + 8'(i));
        in_valid  = 1'b1;
        in_instr  = 8'hB0;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if ({count, overflow, ir_q, out_instr, in_ready} !== {3'd3, 1'b1, 8'hA1, 8'hA2, 1'b1}) begin
            failures++; $display("FAIL full_push_pop: cnt=%0d of=%b ir=%h head=%h rdy=%b, want 3 1 a1 a2 1", count, overflow, ir_q, out_instr, in_ready);
        end
    endtask

    task automatic test_flush();
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 8'hF0;
        out_ready = 1'b1;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if ({count, out_valid, overflow, ir_q, ir_valid, out_instr} !== {3'd0, 1'b0, 1'b0, 8'hA1, 1'b1, 8'h00}) begin
            failures++; $display("FAIL flush_prio: cnt=%0d ov=%b of=%b ir=%h irv=%b oi=%h, want 0 0 0 a1 1 00", count, out_valid, overflow, ir_q, ir_valid, out_instr);
        end
    endtask

    task automatic test_async_reset();
        push_one(8'hC1);
        push_one(8'hC2);
        checks++; if (count !== 3'd2) begin
            failures++; $display("FAIL pre_reset: cnt=%0d want 2", count);
        end
        #2 rst = 1'b1;
        #1;
        checks++; if ({in_ready, out_valid, out_instr, out_opcode, out_operand, ir_q, ir_valid, count, overflow}
                      !== {1'b1, 1'b0, 8'h00, 4'h0, 4'h0, 8'h00, 1'b0, 3'd0, 1'b0}) begin
            failures++; $display("FAIL async_reset: rdy=%b ov=%b oi=%h ir=%h irv=%b cnt=%0d of=%b", in_ready, out_valid, out_instr, ir_q, ir_valid, count, overflow);
        end
        #1 rst = 1'b0;
        step();
        checks++; if ({count, out_valid} !== {3'd0, 1'b0}) begin
            failures++; $display("FAIL post_reset: cnt=%0d ov=%b, want 0 0", count, out_valid);
        end
        push_one(8'hD1);
        checks++; if ({count, out_instr} !== {3'd1, 8'hD1}) begin
            failures++; $display("FAIL post_reset_push: cnt=%0d head=%h, want 1 d1", count, out_instr);
        end
    endtask

    initial begin
        test_reset();
        test_basic_push();
        test_fill_overflow();
        test_back_to_back();
        test_full_push_pop();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_queue_reg.md
INSTR_QUEUE_REG -- requirements
Module: instr_queue_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, instruction width in bits (WIDTH >= OPCODE_W+1).
REQ-002 SHALL have parameter DEPTH, default 4, queue entries (power of two, >= 2).
REQ-003 SHALL have parameter OPCODE_W, default 4, opcode field width (upper bits of instruction).
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL provide ports, one per line:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- flush  input  1  synchronous queue clear
- in_valid  input  1  producer offers in_instr
- in_ready  output  1  queue can accept
- in_instr  input  WIDTH  instruction word
- out_valid  output  1  head entry present
- out_ready  input  1  consumer takes head
- out_instr  output  WIDTH  head entry
- out_opcode  output  OPCODE_W  out_instr[WIDTH-1 -: OPCODE_W]
- out_operand  output  WIDTH-OPCODE_W  remaining low bits of out_instr
- ir_q  output  WIDTH  instruction register: last popped instruction
- ir_valid  output  1  ir_q holds a popped instruction
- count  output  clog2(DEPTH)+1  current occupancy
- overflow  output  1  sticky: push attempted while full

Function
REQ-006 SHALL implement a DEPTH-entry FIFO with write pointer, read pointer and occupancy counter; pointers wrap modulo DEPTH.
REQ-007 SHALL drive in_ready = (count != DEPTH), from registered state only; no combinational path from out_ready to in_ready.
REQ-008 SHALL push in_instr on a rising edge when in_valid && in_ready.
REQ-009 SHALL pop the head on a rising edge when out_valid && out_ready.
REQ-010 SHALL drive out_valid = (count != 0); no bypass: a push into an empty queue gives out_valid high the cycle after (latency 1).
REQ-011 SHALL drive out_instr, out_opcode, out_operand from the head entry when out_valid is 1, and all-zero when out_valid is 0.
REQ-012 On simultaneous push and pop, count SHALL be unchanged, both pointers advance, data order preserved.
REQ-013 When full, in_valid SHALL be ignored even if a pop occurs in the same cycle; overflow SHALL set to 1 on that edge.
REQ-014 When empty, out_ready SHALL have no effect; pointers, count, ir_q unchanged.
REQ-015 On each pop, ir_q SHALL load the popped word and ir_valid SHALL set to 1; otherwise both hold.
REQ-016 flush SHALL have priority over push and pop: on that edge count, pointers and overflow go to 0, same-cycle push and pop are discarded; ir_q and ir_valid hold.
REQ-017 count SHALL never exceed DEPTH nor underflow below 0.
REQ-018 Storage array SHALL need no reset; its contents SHALL never be visible while out_valid is 0.

Reset
REQ-019 While rst is 1, asynchronously: count=0, pointers=0, in_ready=1, out_valid=0, out_instr/out_opcode/out_operand=0, ir_q=0, ir_valid=0, overflow=0.
REQ-020 rst asserted mid-operation SHALL discard all queued entries; the first edge after release behaves as from an empty queue.

Verification
REQ-021 Reset then push 0xA5 (defaults) -> next cycle out_valid=1, out_opcode=0xA, out_operand=0x5, count=1.
REQ-022 Push 0x11,0x22,0x33,0x44 with out_ready=0 -> count=4, in_ready=0; fifth push 0x55 -> rejected, overflow=1; pop four -> 0x11..0x44 in order, ir_q=0x44, ir_valid=1.
REQ-023 Queue holding 2 entries, in_valid=out_ready=1 for 6 cycles with 0x01..0x06 -> count stays 2, output order intact through pointer wrap.
REQ-024 Full queue, in_valid=out_ready=1 -> pop occurs, push rejected, count=3, overflow=1.
REQ-025 Queue holding 3 entries, flush=1 with in_valid=out_ready=1 -> count=0, out_valid=0, overflow=0, ir_q unchanged.
REQ-026 rst pulsed between clock edges with 2 entries queued -> all outputs at reset values immediately, before next edge.
